// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes and debounces an active-low button,
// then reports press/release/long-press pulses and a held level.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button_n,
  output logic pressed,
  output logic released,
  output logic long_press,
  output logic held
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HELD = 2'b01,
    LONG = 2'b10
  } state_t;

  logic              r_s1;
  logic              r_s2;
  logic              r_db_n;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_held;
  logic              r_pressed;
  logic              r_released;
  logic              r_long_press;
  logic [HOLD_W-1:0] r_hold_cnt;
  state_t            r_state;

  logic              w_press;
  logic              w_release;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_long_press_nxt;

  // Two-flop synchronizer; idles released (high).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= button_n;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has persisted DEBOUNCE_CYCLES edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_db_n   <= 1'b1;
      r_db_cnt <= '0;
    end else if (r_s2 == r_db_n) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_n   <= r_s2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // r_held lags r_db_n by one edge, so their disagreement marks an accepted edge.
  assign w_press   = ~r_db_n & ~r_held;
  assign w_release =  r_db_n &  r_held;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_held     <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_held     <= ~r_db_n;
      r_pressed  <= w_press;
      r_released <= w_release;
    end
  end

  // Hold-time FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_long_press <= w_long_press_nxt;
    end
  end

  // Release is checked before the threshold so it wins a same-edge tie.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_long_press_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_state_nxt    = HELD;
          w_hold_cnt_nxt = '0;
        end
      end
      HELD: begin
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt      = LONG;
          w_long_press_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      LONG: begin
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_hold_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  assign pressed    = r_pressed;
  assign released   = r_released;
  assign long_press = r_long_press;
  assign held       = r_held;

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); legal range >= 1.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 50000000, the number of cycles from pressed to long_press (1 s at 50 MHz); legal range >= 2.
REQ-003 The block SHALL have port clock, input, 1 bit: 50 MHz system clock, all state updated on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port button_n, input, 1 bit: raw inverting push button, asynchronous to clock (0 = pushed).
REQ-006 The block SHALL have port pressed, output, 1 bit: one-cycle pulse when a debounced press is accepted.
REQ-007 The block SHALL have port released, output, 1 bit: one-cycle pulse when a debounced release is accepted.
REQ-008 The block SHALL have port long_press, output, 1 bit: one-cycle pulse when a press has been held for LONG_PRESS_CYCLES.
REQ-009 The block SHALL have port held, output, 1 bit: level, high while the debounced button state is pushed.

Function
REQ-010 button_n SHALL pass through a two-flop synchronizer (s1, s2), both resetting to 1, before any other use.
REQ-011 A debounced level db_n (reset 1) SHALL change to s2 only after s2 has differed from db_n on DEBOUNCE_CYCLES consecutive clock edges.
REQ-012 The debounce counter SHALL clear whenever s2 equals db_n, and also on the edge at which db_n updates; it SHALL never wrap.
REQ-013 pressed SHALL be high for exactly one cycle, starting DEBOUNCE_CYCLES+2 edges after the first edge sampling button_n low, provided button_n stays low.
REQ-014 released SHALL behave symmetrically on a debounced 0->1 change of db_n, with the same latency.
REQ-015 held SHALL equal NOT db_n, registered, so it rises in the same cycle as pressed and falls in the same cycle as released.
REQ-016 An FSM SHALL have states IDLE, HELD and LONG; reset state is IDLE.
REQ-017 IDLE->HELD SHALL occur on an accepted press; the hold counter is cleared on that edge.
REQ-018 In HELD the hold counter SHALL increment every cycle; on reaching LONG_PRESS_CYCLES-1 the FSM SHALL go to LONG and pulse long_press one cycle, i.e. exactly LONG_PRESS_CYCLES cycles after pressed.
REQ-019 In LONG the hold counter SHALL stop, and long_press SHALL NOT repeat however long the button is held.
REQ-020 An accepted release in HELD or LONG SHALL return the FSM to IDLE and clear the hold counter.
REQ-021 If the release and the long-press threshold occur on the same edge, release SHALL win: released pulses, long_press stays 0 and the FSM goes to IDLE.
REQ-022 pressed, released and long_press SHALL be mutually exclusive except as ruled by REQ-021; pressed and released SHALL never be high together.
REQ-023 Counter widths SHALL be the clog2 of their parameter, with no overflow for any legal parameter value.

Reset
REQ-024 reset_n low SHALL immediately, without a clock edge, force s1=s2=db_n=1, both counters to 0, FSM to IDLE and pressed=released=long_press=held=0.
REQ-025 Reset mid-debounce or mid-hold SHALL discard progress; if button_n is still low after reset release, a new press SHALL be debounced and reported from scratch.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
REQ-026 The bench SHALL pulse reset_n low between clock edges with button_n=0 mid-count -> all outputs 0 immediately; with button_n held low, pressed fires 6 edges after reset release.
REQ-027 The bench SHALL apply button_n low from edge t for 10 cycles -> pressed=1 only in cycle t+6, held=1 from t+6, long_press stays 0.
REQ-028 The bench SHALL apply a bounce: button_n low 3, high 1, low 3, high 5 cycles -> pressed, held and released all stay 0 throughout.
REQ-029 The bench SHALL hold button_n low for 40 cycles from t -> pressed at t+6, long_press once at t+22, no further long_press, held=1 to the end.
REQ-030 The bench SHALL, after a 10-cycle press, drive button_n high at edge r -> released=1 only at r+6, held=0 from r+6, FSM IDLE, no long_press.
REQ-031 The bench SHALL time the release so its acceptance lands on the long-press threshold edge -> released=1, long_press=0, FSM IDLE.
